rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, ROM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, ROM data width.
REQ-003 The block SHALL have parameter ROM_DEPTH, default 7, number of valid ROM words.
REQ-004 The block SHALL have parameter TIMEOUT, default 15, maximum cycles to wait for rom_ack_i.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset: sys_clk input 1, rising-edge clock; sys_rst_n input 1, asynchronous active-low reset.
REQ-006 The block SHALL have the following master-side ports, with X in {0,1}; port 0 is instruction fetch and port 1 is data load:
- mX_stb_i input 1: request, held until mX_ack_o.
- mX_addr_i input ADDR_W: word address.
- mX_ack_o output 1: one-cycle completion pulse.
- mX_data_o output DATA_W: read data, valid with mX_ack_o.
- mX_err_o output 1: error flag, valid with mX_ack_o.
REQ-007 The block SHALL have the following ROM-side ports:
- rom_stb_o output 1: ROM strobe.
- rom_addr_o output ADDR_W: ROM address.
- rom_ack_i input 1: ROM completion, data valid this cycle.
- rom_data_i input DATA_W: ROM read data.

Function
REQ-008 The block SHALL implement FSM states IDLE, REQ and RESP, with all outputs registered.
REQ-009 IDLE: if any mX_stb_i is high, the block SHALL latch the winner's index and address and move to REQ next cycle; otherwise it SHALL stay in IDLE.
REQ-010 Arbitration SHALL be round-robin: if both request, grant the port not granted last; last_grant updates on each grant.
REQ-011 REQ: rom_stb_o SHALL be 1 and rom_addr_o SHALL be the latched address for every REQ cycle, and 0 in all other states.
REQ-012 REQ: on rom_ack_i=1 the block SHALL capture rom_data_i, clear the error flag and move to RESP.
REQ-013 A wait counter SHALL clear on entering REQ and increment each REQ cycle without ack; when it reaches TIMEOUT, the block SHALL move to RESP with error=1 and data=0.
REQ-014 If ack and timeout occur in the same cycle, ack SHALL win: data is captured and error=0.
REQ-015 Out-of-range: if the latched address >= ROM_DEPTH, the block SHALL go IDLE->RESP directly with error=1, data=0 and no rom_stb_o pulse.
REQ-016 RESP: the granted mX_ack_o, mX_data_o and mX_err_o SHALL be driven for exactly one cycle; then the block SHALL return to IDLE.
REQ-017 The non-granted port's outputs SHALL stay 0.
REQ-018 mX_data_o and mX_err_o SHALL be 0 whenever mX_ack_o=0.
REQ-019 Latency with the ROM acking in the first REQ cycle: stb sampled in cycle 0, rom_stb_o high in cycle 1, mX_ack_o in cycle 2.
REQ-020 Masters SHALL deassert mX_stb_i from the cycle after mX_ack_o; a still-high stb in IDLE SHALL be treated as a new request.
REQ-021 Address changes on mX_addr_i after grant SHALL be ignored until the next IDLE.

Reset
REQ-022 Asserting sys_rst_n=0 SHALL asynchronously force: state IDLE, rom_stb_o=0, rom_addr_o=0, all mX_ack_o/mX_data_o/mX_err_o=0, wait counter=0, last_grant=1 (port 0 wins the first tie).
REQ-023 Reset mid-transaction SHALL abandon the transaction with no ack issued; a ROM ack arriving after reset release while in IDLE SHALL be ignored.

Structure
REQ-024 ADDR_W/DATA_W defaults, the state encoding (IDLE=0, REQ=1, RESP=2) and the error code SHALL live in the shared memory-commutator package.
REQ-025 One sub-module, rr_arb2 (2-input round-robin grant with last_grant register), SHALL be used; the FSM, timeout counter and muxing stay in rom_arbiter.

Verification
REQ-026 Single fetch: m0 stb, addr=3; ROM acks in cycle 1 with 0xFFFFFFFF -> m0_ack_o=1 in cycle 2, m0_data_o=0xFFFFFFFF, m0_err_o=0.
REQ-027 Contention: m0 and m1 stb together at reset exit, addr 1 and 2 -> m0 served first, then m1; rom_addr_o sequence 1, 2; a following tie grants m0 again.
REQ-028 Timeout: m1 stb, addr=4, rom_ack_i held 0 -> rom_stb_o high for 15 cycles, m1_ack_o=1, m1_err_o=1, m1_data_o=0.
REQ-029 Ack on the 15th wait cycle with 0x12345678 -> m1_err_o=0, m1_data_o=0x12345678.
REQ-030 Out of range: m0 addr=7 -> rom_stb_o never asserted, m0_ack_o in cycle 1 after grant, m0_err_o=1.
REQ-031 Reset mid-REQ: drop sys_rst_n while rom_stb_o=1 -> all outputs 0 immediately, no mX_ack_o after release, next request served normally.

Source files
------------

// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the two-master ROM commutator: bus width defaults,
// controller state encoding and the error code returned with a response.
package rom_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_FAIL = 1'b1;

endpackage

// File: rtl/rom_arbiter_rr_arb2.sv
// Two-input round-robin grant; last_grant resets to 1 so port 0 wins the first tie.
module rr_arb2
  import rom_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_valid_o = |req_i;
    if (&req_i) begin
      gnt_idx_o = ~last_q;
    end else begin
      gnt_idx_o = req_i[1];
    end
    last_d = last_q;
    if (accept_i && gnt_valid_o) begin
      last_d = gnt_idx_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates an instruction-fetch and a data-load master onto one ROM port,
// with a bounded wait for the ROM ack and out-of-range address rejection.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ROM_DEPTH = 7,
  parameter int TIMEOUT   = 15
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              m0_stb_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_err_o,
  input  logic              m1_stb_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_err_o,
  output logic              rom_stb_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_ack_i,
  input  logic [DATA_W-1:0] rom_data_i
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(ROM_DEPTH);

  arb_state_e              state_q, state_d;
  logic                    gnt_q, gnt_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    rom_stb_q, rom_stb_d;
  logic [ADDR_W-1:0]       rom_addr_q, rom_addr_d;
  logic [1:0]              ack_q, ack_d;
  logic [1:0]              err_q, err_d;
  logic [1:0][DATA_W-1:0]  data_q, data_d;

  logic                    arb_vld;
  logic                    arb_idx;
  logic                    accept;
  logic [ADDR_W-1:0]       win_addr;

  rr_arb2 u_rr_arb2 (
    .clk         (sys_clk),
    .rst_n       (sys_rst_n),
    .req_i       ({m1_stb_i, m0_stb_i}),
    .accept_i    (accept),
    .gnt_valid_o (arb_vld),
    .gnt_idx_o   (arb_idx)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    wait_d     = wait_q;
    rom_stb_d  = 1'b0;
    rom_addr_d = '0;
    ack_d      = '0;
    err_d      = '0;
    data_d     = '0;
    accept     = 1'b0;
    win_addr   = arb_idx ? m1_addr_i : m0_addr_i;

    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          accept = 1'b1;
          gnt_d  = arb_idx;
          wait_d = '0;
          // Addresses past the populated ROM are answered without touching the ROM.
          if (win_addr >= DEPTH_A) begin
            state_d        = ST_RESP;
            ack_d[arb_idx] = 1'b1;
            err_d[arb_idx] = ERR_FAIL;
          end else begin
            state_d    = ST_REQ;
            rom_stb_d  = 1'b1;
            rom_addr_d = win_addr;
          end
        end
      end
      ST_REQ: begin
        // A late ack still wins over a timeout landing in the same cycle.
        if (rom_ack_i) begin
          state_d       = ST_RESP;
          ack_d[gnt_q]  = 1'b1;
          err_d[gnt_q]  = ERR_NONE;
          data_d[gnt_q] = rom_data_i;
        end else if (wait_q == WAIT_LAST) begin
          state_d      = ST_RESP;
          ack_d[gnt_q] = 1'b1;
          err_d[gnt_q] = ERR_FAIL;
        end else begin
          wait_d     = wait_q + WAIT_W'(1);
          rom_stb_d  = 1'b1;
          rom_addr_d = rom_addr_q;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        wait_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      wait_q     <= '0;
      rom_stb_q  <= 1'b0;
      rom_addr_q <= '0;
      ack_q      <= '0;
      err_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      wait_q     <= wait_d;
      rom_stb_q  <= rom_stb_d;
      rom_addr_q <= rom_addr_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      data_q     <= data_d;
    end
  end

  assign rom_stb_o  = rom_stb_q;
  assign rom_addr_o = rom_addr_q;
  assign m0_ack_o   = ack_q[0];
  assign m0_err_o   = err_q[0];
  assign m0_data_o  = data_q[0];
  assign m1_ack_o   = ack_q[1];
  assign m1_err_o   = err_q[1];
  assign m1_data_o  = data_q[1];

endmodule

// File: tb/tb_rom_arbiter.sv
// Randomized and directed bench for rom_arbiter against a transaction-level model.
module tb_rom_arbiter;

  localparam int ROM_DEPTH = 7;
  localparam int TIMEOUT   = 15;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        m0_stb_i, m1_stb_i;
  logic [15:0] m0_addr_i, m1_addr_i;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic        rom_stb_o;
  logic [15:0] rom_addr_o;
  logic        rom_ack_i;
  logic [31:0] rom_data_i;

  int errors = 0;
  int checks = 0;
  int last_gnt = 1;
  bit s0 = 0, s1 = 0;

  rom_arbiter #(.ADDR_W(16), .DATA_W(32), .ROM_DEPTH(ROM_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m0_stb_i(m0_stb_i), .m0_addr_i(m0_addr_i), .m0_ack_o(m0_ack_o),
    .m0_data_o(m0_data_o), .m0_err_o(m0_err_o),
    .m1_stb_i(m1_stb_i), .m1_addr_i(m1_addr_i), .m1_ack_o(m1_ack_o),
    .m1_data_o(m1_data_o), .m1_err_o(m1_err_o),
    .rom_stb_o(rom_stb_o), .rom_addr_o(rom_addr_o),
    .rom_ack_i(rom_ack_i), .rom_data_i(rom_data_i)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic req(input int port, input logic [15:0] addr);
    if (port == 0) begin s0 = 1; m0_stb_i = 1'b1; m0_addr_i = addr; end
    else begin s1 = 1; m1_stb_i = 1'b1; m1_addr_i = addr; end
  endtask

  // Called just after a negedge of an idle cycle with requests already set;
  // that cycle is cycle 0. Serves exactly one request.
  task automatic run_txn(input int ack_dly, input logic [31:0] rdata);
    int          win, stb_cnt, exp_stb, exp_cyc;
    logic [15:0] addr;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        w_ack, w_err, l_ack, l_err;
    logic [31:0] w_data, l_data;
    bit          done;
    win      = (s0 && s1) ? ((last_gnt == 0) ? 1 : 0) : (s1 ? 1 : 0);
    last_gnt = win;
    addr     = win ? m1_addr_i : m0_addr_i;
    if (addr >= ROM_DEPTH) begin
      exp_stb = 0; exp_err = 1'b1; exp_data = 32'h0;
    end else if (ack_dly >= 1 && ack_dly <= TIMEOUT) begin
      exp_stb = ack_dly; exp_err = 1'b0; exp_data = rdata;
    end else begin
      exp_stb = TIMEOUT; exp_err = 1'b1; exp_data = 32'h0;
    end
    exp_cyc = exp_stb + 1;
    stb_cnt = 0;
    done    = 0;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge sys_clk);
      rom_ack_i  = 1'b0;
      rom_data_i = $urandom;
      w_ack  = win ? m1_ack_o  : m0_ack_o;
      w_err  = win ? m1_err_o  : m0_err_o;
      w_data = win ? m1_data_o : m0_data_o;
      l_ack  = win ? m0_ack_o  : m1_ack_o;
      l_err  = win ? m0_err_o  : m1_err_o;
      l_data = win ? m0_data_o : m1_data_o;
      if (rom_stb_o) begin
        stb_cnt++;
        checks++;
        if (rom_addr_o !== addr) begin
          errors++; $display("FAIL rom_addr: got %h expected %h (cycle %0d)", rom_addr_o, addr, n);
        end
        if (stb_cnt == ack_dly) begin rom_ack_i = 1'b1; rom_data_i = rdata; end
        if (stb_cnt == 1) begin
          if (win == 1) m1_addr_i = 16'($urandom); else m0_addr_i = 16'($urandom);
        end
      end else begin
        checks++;
        if (rom_addr_o !== 16'h0) begin
          errors++; $display("FAIL rom_addr_idle: got %h expected 0", rom_addr_o);
        end
      end
      checks++;
      if ({l_ack, l_err, l_data} !== 34'h0) begin
        errors++; $display("FAIL loser_quiet: got ack=%b err=%b data=%h expected all 0", l_ack, l_err, l_data);
      end
      if (w_ack === 1'b1) begin
        done = 1;
        checks++;
        if (n != exp_cyc) begin
          errors++; $display("FAIL ack_cycle: got %0d expected %0d", n, exp_cyc);
        end
        checks++;
        if (stb_cnt != exp_stb) begin
          errors++; $display("FAIL stb_cycles: got %0d expected %0d", stb_cnt, exp_stb);
        end
        checks++;
        if (w_data !== exp_data) begin
          errors++; $display("FAIL resp_data: got %h expected %h", w_data, exp_data);
        end
        checks++;
        if (w_err !== exp_err) begin
          errors++; $display("FAIL resp_err: got %b expected %b", w_err, exp_err);
        end
        if (win == 1) begin s1 = 0; m1_stb_i = 1'b0; end
        else begin s0 = 0; m0_stb_i = 1'b0; end
      end else begin
        checks++;
        if ({w_err, w_data} !== 33'h0) begin
          errors++; $display("FAIL winner_quiet: got err=%b data=%h expected 0", w_err, w_data);
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL ack_wait: got no ack in 40 cycles expected ack at cycle %0d", exp_cyc);
    end
    @(negedge sys_clk);
    rom_ack_i = 1'b0;
    checks++;
    if ({rom_stb_o, m0_ack_o, m1_ack_o} !== 3'b000) begin
      errors++; $display("FAIL back_to_idle: got stb=%b ack0=%b ack1=%b expected 000", rom_stb_o, m0_ack_o, m1_ack_o);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({rom_stb_o, rom_addr_o, m0_ack_o, m0_err_o, m0_data_o, m1_ack_o, m1_err_o, m1_data_o} !== '0) begin
      errors++;
      $display("FAIL %s: got stb=%b addr=%h ack=%b%b err=%b%b d0=%h d1=%h expected all 0", name,
               rom_stb_o, rom_addr_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_data_o, m1_data_o);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    m0_stb_i = 0; m1_stb_i = 0; m0_addr_i = 0; m1_addr_i = 0;
    rom_ack_i = 0; rom_data_i = 0;
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset_state");
  endtask

  task automatic test_contention();
    req(0, 16'd1);
    req(1, 16'd2);
    sys_rst_n = 1'b1;
    last_gnt  = 1;
    run_txn(1, $urandom);
    run_txn(1, $urandom);
    req(0, 16'd4);
    req(1, 16'd5);
    run_txn(2, $urandom);
    run_txn(3, $urandom);
  endtask

  task automatic test_single_fetch();
    req(0, 16'd3);
    run_txn(1, 32'hFFFF_FFFF);
  endtask

  task automatic test_timeout();
    req(1, 16'd4);
    run_txn(0, 32'hAAAA_5555);
    req(1, 16'd4);
    run_txn(TIMEOUT, 32'h1234_5678);
  endtask

  task automatic test_out_of_range();
    req(0, 16'd7);
    run_txn(1, 32'hCAFE_F00D);
    req(1, 16'hFFFF);
    run_txn(1, 32'hCAFE_F00D);
  endtask

  task automatic test_reset_mid_req();
    req(0, 16'd2);
    @(negedge sys_clk);
    checks++;
    if (rom_stb_o !== 1'b1) begin
      errors++; $display("FAIL mid_req_stb: got %b expected 1", rom_stb_o);
    end
    #2 sys_rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    rom_ack_i = 1'b1; rom_data_i = 32'hDEAD_BEEF;
    m0_stb_i = 1'b0; s0 = 0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    last_gnt  = 1;
    repeat (3) begin
      @(negedge sys_clk);
      check_all_zero("after_release");
    end
    rom_ack_i = 1'b0;
    req(0, 16'd5);
    run_txn(2, 32'h0BAD_CAFE);
  endtask

  task automatic test_random();
    int dly;
    for (int i = 0; i < 40; i++) begin
      if (!s0 && $urandom_range(0, 1) == 1) req(0, 16'($urandom_range(0, 9)));
      if (!s1 && $urandom_range(0, 1) == 1) req(1, 16'($urandom_range(0, 9)));
      if (!s0 && !s1) req(int'($urandom_range(0, 1)), 16'($urandom_range(0, 9)));
      dly = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 18)) : int'($urandom_range(1, 4));
      run_txn(dly, $urandom);
    end
    while (s0 || s1) run_txn(1, $urandom);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_fetch();
    test_timeout();
    test_out_of_range();
    test_reset_mid_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
